// File: rtl/vdma_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vdma_pkg
// Brief    : Shared state encodings and AXI response codes for the VDMA memory slave.
// Revision : 1.0
// ============================================================================
package vdma_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/vdma_axi4_mem_slave_if.sv
`default_nettype none
// ============================================================================
// Interface : vdma_axi4_mem_slave_if
// Brief     : AXI4 frame-buffer bus between a VDMA master and the RAM-backed slave.
// Revision  : 1.0
// ============================================================================
interface vdma_axi4_mem_slave_if #(
  parameter int ASIZE          = 29,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4,
  parameter int BURST_LEN_SIZE = 8
);

  logic [IDSIZE-1:0]         awid;
  logic [ASIZE-1:0]          awaddr;
  logic [BURST_LEN_SIZE-1:0] awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic                      awvalid;
  logic                      awready;

  logic [AXI_DSIZE-1:0]      wdata;
  logic [AXI_DSIZE/8-1:0]    wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [IDSIZE-1:0]         bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [IDSIZE-1:0]         arid;
  logic [ASIZE-1:0]          araddr;
  logic [BURST_LEN_SIZE-1:0] arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arqos;
  logic                      arvalid;
  logic                      arready;

  logic [IDSIZE-1:0]         rid;
  logic [AXI_DSIZE-1:0]      rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/vdma_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : vdma_sdp_ram
// Brief    : Simple dual-port RAM, byte-enable write, registered read with enable.
// Revision : 1.0
// ============================================================================
module vdma_sdp_ram #(
  parameter int DW = 256,
  parameter int AW = 10
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic [DW/8-1:0] i_wbe,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Separate read process samples the pre-write word on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/vdma_axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : vdma_axi4_mem_slave
// Brief    : AXI4 INCR-burst slave backing a VDMA frame-buffer port with on-chip RAM.
//            Optional macro: VDMA_MEM_SLV_RANGE_CHECK_EN (SLVERR on out-of-range beats).
// Revision : 1.0
// ============================================================================
module vdma_axi4_mem_slave
  import vdma_pkg::*;
#(
  parameter int ASIZE          = 29,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4,
  parameter int BURST_LEN_SIZE = 8,
  parameter int MEM_AW         = 10
) (
  input wire logic             axi_aclk,
  input wire logic             axi_reset,
  vdma_axi4_mem_slave_if.slave axi
);

  localparam int OFFS   = $clog2(AXI_DSIZE/8);
  localparam int IDX_W  = ASIZE - OFFS;
  localparam int IDXE_W = IDX_W + 1;
  localparam int CNT_W  = BURST_LEN_SIZE + 1;

  // ---------------------------------------------------------------- write side
  wr_state_t                 r_wr_state;
  wr_state_t                 w_wr_state_nxt;
  logic [IDSIZE-1:0]         r_wr_id;
  logic [MEM_AW-1:0]         r_wr_idx;
  logic [BURST_LEN_SIZE-1:0] r_wr_len;
  logic [BURST_LEN_SIZE-1:0] r_wr_cnt;
  logic                      r_wr_oor;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_w_last;
  logic                      w_b_hs;
  logic                      w_aw_oor;

  assign w_aw_hs  = axi.awvalid && r_awready;
  assign w_w_hs   = axi.wvalid && r_wready;
  assign w_w_last = w_w_hs && (r_wr_cnt == r_wr_len);
  assign w_b_hs   = r_bvalid && axi.bready;

`ifdef VDMA_MEM_SLV_RANGE_CHECK_EN
  logic [IDXE_W-1:0] w_aw_end;
  // Last beat index is the largest, so one compare covers the whole burst.
  assign w_aw_end = {1'b0, axi.awaddr[ASIZE-1:OFFS]} + IDXE_W'(axi.awlen);
  assign w_aw_oor = |w_aw_end[IDXE_W-1:MEM_AW];
`else
  assign w_aw_oor = 1'b0;
`endif

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_aw_hs)  w_wr_state_nxt = W_DATA;
      W_DATA:  if (w_w_last) w_wr_state_nxt = W_RESP;
      W_RESP:  if (w_b_hs)   w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_id    <= '0;
      r_wr_idx   <= '0;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
      r_wr_oor   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_awready  <= (w_wr_state_nxt == W_IDLE);
      r_wready   <= (w_wr_state_nxt == W_DATA);
      r_bvalid   <= (w_wr_state_nxt == W_RESP);
      if (w_aw_hs) begin
        r_wr_id  <= axi.awid;
        r_wr_idx <= axi.awaddr[OFFS +: MEM_AW];
        r_wr_len <= axi.awlen;
        r_wr_cnt <= '0;
        r_wr_oor <= w_aw_oor;
      end
      if (w_w_hs) begin
        r_wr_idx <= r_wr_idx + MEM_AW'(1);
        r_wr_cnt <= r_wr_cnt + BURST_LEN_SIZE'(1);
      end
      if (w_w_last) begin
        r_bresp <= r_wr_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axi.awready = r_awready;
  assign axi.wready  = r_wready;
  assign axi.bvalid  = r_bvalid;
  assign axi.bid     = r_wr_id;
  assign axi.bresp   = r_bresp;

  // ----------------------------------------------------------------- read side
  rd_state_t         r_rd_state;
  rd_state_t         w_rd_state_nxt;
  logic [IDXE_W-1:0] r_rd_idx;
  logic [CNT_W-1:0]  r_rd_rem;
  logic [IDSIZE-1:0] r_rid;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic [1:0]        r_rresp;
  logic              r_rd_oor_q;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_r_done;
  logic              w_fetch;
  logic              w_rd_oor;
  logic [AXI_DSIZE-1:0] w_ram_q;

  assign w_ar_hs  = axi.arvalid && r_arready;
  assign w_r_hs   = r_rvalid && axi.rready;
  assign w_r_done = w_r_hs && r_rlast;
  // Fetch only into an empty or draining output stage so stalled data holds.
  assign w_fetch  = (r_rd_state == R_DATA) && (r_rd_rem != '0) && (!r_rvalid || axi.rready);

`ifdef VDMA_MEM_SLV_RANGE_CHECK_EN
  assign w_rd_oor = |r_rd_idx[IDXE_W-1:MEM_AW];
`else
  assign w_rd_oor = 1'b0;
`endif

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs)  w_rd_state_nxt = R_DATA;
      R_DATA:  if (w_r_done) w_rd_state_nxt = R_IDLE;
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rid      <= '0;
      r_rd_idx   <= '0;
      r_rd_rem   <= '0;
      r_rd_oor_q <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_arready  <= (w_rd_state_nxt == R_IDLE);
      if (w_ar_hs) begin
        r_rid    <= axi.arid;
        r_rd_idx <= {1'b0, axi.araddr[ASIZE-1:OFFS]};
        r_rd_rem <= {1'b0, axi.arlen} + CNT_W'(1);
      end
      if (w_fetch) begin
        r_rd_idx   <= r_rd_idx + IDXE_W'(1);
        r_rd_rem   <= r_rd_rem - CNT_W'(1);
        r_rvalid   <= 1'b1;
        r_rlast    <= (r_rd_rem == CNT_W'(1));
        r_rresp    <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
        r_rd_oor_q <= w_rd_oor;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign axi.arready = r_arready;
  assign axi.rvalid  = r_rvalid;
  assign axi.rlast   = r_rlast;
  assign axi.rresp   = r_rresp;
  assign axi.rid     = r_rid;
  assign axi.rdata   = r_rd_oor_q ? '0 : w_ram_q;

  vdma_sdp_ram #(
    .DW (AXI_DSIZE),
    .AW (MEM_AW)
  ) u_ram (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .i_we    (w_w_hs && !r_wr_oor),
    .i_waddr (r_wr_idx),
    .i_wdata (axi.wdata),
    .i_wbe   (axi.wstrb),
    .i_re    (w_fetch),
    .i_raddr (r_rd_idx[MEM_AW-1:0]),
    .o_rdata (w_ram_q)
  );

  // Sideband fields this slave accepts but has no use for.
  logic w_unused_ok;
`ifdef VDMA_MEM_SLV_RANGE_CHECK_EN
  assign w_unused_ok = &{1'b0, w_aw_end[MEM_AW-1:0]};
`else
  assign w_unused_ok = &{1'b0, axi.awaddr[ASIZE-1:OFFS+MEM_AW], r_rd_idx[IDXE_W-1:MEM_AW]};
`endif
  logic w_unused_side;
  assign w_unused_side = &{1'b0, w_unused_ok, axi.wlast,
                           axi.awaddr[OFFS-1:0], axi.awsize, axi.awburst, axi.awlock,
                           axi.awcache, axi.awprot, axi.awqos,
                           axi.araddr[OFFS-1:0], axi.arsize, axi.arburst, axi.arlock,
                           axi.arcache, axi.arprot, axi.arqos};

endmodule
`default_nettype wire
